random_word_arbiter: RTL and testbench
======================================

# random_word_arbiter

Round-robin arbiter that shares one Galois LFSR among `REQ_NUM` requesters, such as random state generators and duration counters. Each granted request receives a fresh pseudo-random word. The LFSR advances only on a grant, so the word sequence is deterministic and is never duplicated across requesters. The block sits between the random-pattern consumers and a single shared randomness source, which avoids per-channel LFSR instances.

## Interface
- `REQ_NUM`, 4: number of requesters, 2..16
- `DATA_WIDTH`, 16: LFSR and data word width, 8..32
- `LFSR_POLY`, 16'hB400: Galois feedback mask, `DATA_WIDTH` bits wide
- `LFSR_SEED`, 16'hACE1: reset value of the LFSR; must be non-zero
- `i_clk`  in  1  clock; all logic on its rising edge
- `i_s_rst`  in  1  synchronous, active-high reset
- `i_req`  in  `REQ_NUM`  level request per requester
- `o_gnt`  out  `REQ_NUM`  one-hot grant, combinational
- `o_data`  out  `DATA_WIDTH`  current LFSR word, valid when `o_valid`=1
- `o_valid`  out  1  OR-reduction of `o_gnt`

## Operation
- State is two registers:
  - `lfsr` (`DATA_WIDTH` bits), reset to `LFSR_SEED`
  - `last` (`$clog2(REQ_NUM)` bits), the index of the last granted requester, reset to `REQ_NUM`-1
- Arbitration is combinational:
  - search `i_req` starting at index `last`+1, wrapping modulo `REQ_NUM`
  - the first set bit is granted
  - at most one grant per cycle
- Priority after reset: requester 0 is highest.
- `o_data` always equals `lfsr`. A consumer captures `o_data` in the same cycle its `o_gnt` bit is high.
- On a rising edge with `o_valid`=1:
  - `lfsr` <= (`lfsr` >> 1) ^ (`lfsr`[0] ? `LFSR_POLY` : 0)
  - `last` <= the granted index
- With `o_valid`=0, `lfsr` and `last` hold.
- Handshake: `i_req` acts as valid and `o_gnt` as ready. One word transfers per cycle in which both are high.
  - A requester wanting exactly one word drops `i_req` on the edge after its grant.
  - A requester holding `i_req` continuously receives one word per round-robin turn.
- Fairness: with k requesters active, each is granted exactly once in every k consecutive grant cycles.
- A single active requester is granted every cycle, so it gets consecutive LFSR words.
- Lock-up guard: if `lfsr` would become all-zero, `LFSR_SEED` is loaded instead. The guard is unreachable with a valid polynomial and non-zero seed, but it is kept for robustness.

## Timing
- Reset values: `o_gnt`=0 whenever `i_req`=0; `o_data`=`LFSR_SEED`; `o_valid`=0 while `i_req`=0.
- `i_req` to `o_gnt`: 0 cycles (combinational).
- Grant to next word: 1 cycle.
- Throughput: one word per clock.
- While `i_s_rst`=1, `o_gnt` is forced to 0 regardless of `i_req`.
- Reset mid-operation: `lfsr` returns to `LFSR_SEED` and `last` to `REQ_NUM`-1 on that edge. No grant is issued during the reset cycle.
- Wrap-around: with `last`=`REQ_NUM`-1, the search begins at index 0.

## Configuration
- `RANDOM_WORD_ARBITER_SEED_LOAD_EN` defined:
  - adds ports `i_seed_load`  in  1 and `i_seed`  in  `DATA_WIDTH`
  - when `i_seed_load`=1, `o_gnt` is forced to 0 and `lfsr` <= `i_seed`, or `LFSR_SEED` if `i_seed`==0
  - `last` is unchanged
  - `i_s_rst` has priority over `i_seed_load`
- Macro undefined: the ports are absent, and the LFSR is seeded only by reset.

## Structure
- Shared package `random_pkg`:
  - default `LFSR_POLY` and `LFSR_SEED` constants for widths 16 and 32
  - function `lfsr_next(word, poly)`, also used by the bench model
- Sub-module `rr_priority_select`:
  - parameterised by `REQ_NUM`
  - inputs `req` and `last`; output one-hot `gnt`
  - purely combinational and reusable

## Test plan
- Reset, then hold `i_req`=4'b0000 for 10 cycles -> `o_gnt`=0, `o_valid`=0, `o_data`=16'hACE1 throughout.
- `i_req`=4'b0001 for 3 cycles -> `o_gnt`=4'b0001 each cycle; `o_data`=ACE1, E270, 7138.
- `i_req`=4'b1111 held -> grants go 0,1,2,3,0,1,... Words follow `lfsr_next` without repeats or gaps.
- `last`=3 with `i_req`=4'b1001 -> grant 0, then 3, then 0 (wrap-around).
- Assert `i_s_rst` mid-stream with `i_req`=4'b0110 -> `o_gnt`=0 in the reset cycle. The next grant is to requester 1 with `o_data`=ACE1.
- With the macro defined, pulse `i_seed_load` with `i_seed`=0 while `i_req`=4'b0010 -> no grant that cycle, `lfsr`=ACE1. Repeat with `i_seed`=16'h1234 -> the next `o_data`=1234.

Source files
------------

// File: rtl/random_pkg.sv
// -----------------------------------------------------------------------------
// random_pkg
// Shared definitions for the random-word arbiter:
//   - default Galois LFSR polynomial and seed constants for 16 and 32 bit words
//   - lfsr_next(): one right-shifting Galois LFSR step. It operates on a 32-bit
//     container. Narrower words must be zero-extended, and the result truncated.
// -----------------------------------------------------------------------------
package random_pkg;

    localparam int          LFSR_MAX_WIDTH = 32;

    localparam logic [15:0] LFSR_POLY_16   = 16'hB400;
    localparam logic [15:0] LFSR_SEED_16   = 16'hACE1;
    localparam logic [31:0] LFSR_POLY_32   = 32'h80200003;
    localparam logic [31:0] LFSR_SEED_32   = 32'hACE1ACE1;

    // Shift right; when the bit shifted out is set, fold in the polynomial.
    function automatic logic [LFSR_MAX_WIDTH-1:0] lfsr_next(
        input logic [LFSR_MAX_WIDTH-1:0] word,
        input logic [LFSR_MAX_WIDTH-1:0] poly
    );
        return (word >> 1) ^ (word[0] ? poly : '0);
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// -----------------------------------------------------------------------------
// rr_priority_select
// Purely combinational round-robin selector. The search starts at index
// last+1 and wraps modulo REQ_NUM. The first set request bit is granted.
// Ports:
//   req  [REQ_NUM-1:0]  request vector
//   last [IDX_W-1:0]    index of the most recently granted requester
//   gnt  [REQ_NUM-1:0]  one-hot grant; zero when no request is set
// -----------------------------------------------------------------------------
module rr_priority_select #(
    parameter  int REQ_NUM = 4,
    localparam int IDX_W   = $clog2(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [REQ_NUM-1:0] gnt
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        // The final offset (REQ_NUM) revisits 'last' itself. This lets a sole
        // requester keep the grant on every cycle.
        for (int off = 1; off <= REQ_NUM; off++) begin
            int idx;
            idx = (int'(last) + off) % REQ_NUM;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/random_word_arbiter.sv
// -----------------------------------------------------------------------------
// random_word_arbiter
// Round-robin arbiter that shares one Galois LFSR among REQ_NUM requesters.
// A granted requester captures o_data in the same cycle as its grant. The LFSR
// advances only on a grant, so no word is ever handed out twice.
// Ports:
//   i_clk        clock (rising edge)
//   i_s_rst      synchronous active-high reset; forces o_gnt to 0
//   i_req        level request per requester
//   o_gnt        one-hot grant (combinational)
//   o_data       current LFSR word
//   o_valid      OR of o_gnt
// Optional feature (macro RANDOM_WORD_ARBITER_SEED_LOAD_EN):
//   i_seed_load  blocks grants and loads i_seed (or LFSR_SEED if i_seed==0)
//   i_seed       seed value
// -----------------------------------------------------------------------------
module random_word_arbiter
    import random_pkg::*;
#(
    parameter int                    REQ_NUM    = 4,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] LFSR_POLY  = LFSR_POLY_16,
    parameter logic [DATA_WIDTH-1:0] LFSR_SEED  = LFSR_SEED_16
) (
    input  logic                  i_clk,
    input  logic                  i_s_rst,
`ifdef RANDOM_WORD_ARBITER_SEED_LOAD_EN
    input  logic                  i_seed_load,
    input  logic [DATA_WIDTH-1:0] i_seed,
`endif
    input  logic [REQ_NUM-1:0]    i_req,
    output logic [REQ_NUM-1:0]    o_gnt,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid
);

    localparam int IDX_W = $clog2(REQ_NUM);

    logic [DATA_WIDTH-1:0]     lfsr_q, lfsr_d;
    logic [IDX_W-1:0]          last_q, last_d;
    logic [REQ_NUM-1:0]        sel_gnt;
    logic [IDX_W-1:0]          gnt_idx;
    logic                      gnt_block;
    logic [LFSR_MAX_WIDTH-1:0] step_full;
    logic [DATA_WIDTH-1:0]     step;

    rr_priority_select #(
        .REQ_NUM (REQ_NUM)
    ) u_sel (
        .req  (i_req),
        .last (last_q),
        .gnt  (sel_gnt)
    );

    // Grants are suppressed on any cycle in which the LFSR is being (re)seeded.
`ifdef RANDOM_WORD_ARBITER_SEED_LOAD_EN
    assign gnt_block = i_s_rst | i_seed_load;
`else
    assign gnt_block = i_s_rst;
`endif

    assign o_gnt   = gnt_block ? '0 : sel_gnt;
    assign o_valid = |o_gnt;
    assign o_data  = lfsr_q;

    // Encode the one-hot grant into an index for the 'last' register.
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (o_gnt[i]) begin
                gnt_idx = IDX_W'(i);
            end
        end
    end

    // The shared step function works on a 32-bit container. The upper bits stay
    // zero because the input is zero-extended and the polynomial fits DATA_WIDTH.
    assign step_full = lfsr_next(LFSR_MAX_WIDTH'(lfsr_q), LFSR_MAX_WIDTH'(LFSR_POLY));
    assign step      = step_full[DATA_WIDTH-1:0];

    generate
        if (DATA_WIDTH < LFSR_MAX_WIDTH) begin : g_step_pad
            logic unused_step_bits;
            assign unused_step_bits = ^step_full[LFSR_MAX_WIDTH-1:DATA_WIDTH];
        end
    endgenerate

    always_comb begin
        lfsr_d = lfsr_q;
        last_d = last_q;
        if (o_valid) begin
            // Lock-up guard: never let the register settle at all-zero.
            lfsr_d = (step == '0) ? LFSR_SEED : step;
            last_d = gnt_idx;
        end
`ifdef RANDOM_WORD_ARBITER_SEED_LOAD_EN
        if (i_seed_load) begin
            lfsr_d = (i_seed == '0) ? LFSR_SEED : i_seed;
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_s_rst) begin
            lfsr_q <= LFSR_SEED;
            last_q <= IDX_W'(REQ_NUM - 1);
        end else begin
            lfsr_q <= lfsr_d;
            last_q <= last_d;
        end
    end

endmodule

// File: tb/tb_random_word_arbiter.sv
// -----------------------------------------------------------------------------
// tb_random_word_arbiter
// Directed bench for random_word_arbiter (REQ_NUM=4, DATA_WIDTH=16).
// Grants are hand-computed. The expected word is tracked by stepping
// random_pkg::lfsr_next once per expected grant, and the first words are
// also checked against literal constants.
// -----------------------------------------------------------------------------
module tb_random_word_arbiter;
    import random_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_s_rst;
    logic [3:0]  i_req;
    logic [3:0]  o_gnt;
    logic [15:0] o_data;
    logic        o_valid;
`ifdef RANDOM_WORD_ARBITER_SEED_LOAD_EN
    logic        i_seed_load;
    logic [15:0] i_seed;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_word;

    always #5 i_clk = ~i_clk;

    random_word_arbiter #(
        .REQ_NUM    (4),
        .DATA_WIDTH (16),
        .LFSR_POLY  (16'hB400),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .i_clk       (i_clk),
        .i_s_rst     (i_s_rst),
`ifdef RANDOM_WORD_ARBITER_SEED_LOAD_EN
        .i_seed_load (i_seed_load),
        .i_seed      (i_seed),
`endif
        .i_req       (i_req),
        .o_gnt       (o_gnt),
        .o_data      (o_data),
        .o_valid     (o_valid)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end else begin
            $display("ok   %s: %h", tag, actual);
        end
    endtask

    function automatic logic [15:0] step16(input logic [15:0] w);
        logic [31:0] t;
        t = lfsr_next({16'h0, w}, {16'h0, 16'hB400});
        return t[15:0];
    endfunction

    // Inputs are driven 1 time unit after a rising edge. Outputs are checked
    // 1 time unit later, and then the bench advances to the next edge.
    task automatic do_cycle(input string tag, input logic [3:0] req, input logic [3:0] exp_gnt);
        i_req = req;
        #1;
        check({tag, " gnt"},   {28'h0, o_gnt}, {28'h0, exp_gnt});
        check({tag, " valid"}, {31'h0, o_valid}, {31'h0, (exp_gnt != 4'b0)});
        check({tag, " data"},  {16'h0, o_data}, {16'h0, exp_word});
        @(posedge i_clk);
        #1;
        if (exp_gnt != 4'b0) exp_word = step16(exp_word);
    endtask

    initial begin
        logic [3:0] rr_seq [8];
        rr_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        i_s_rst = 1'b1;
        i_req   = 4'b1111;
`ifdef RANDOM_WORD_ARBITER_SEED_LOAD_EN
        i_seed_load = 1'b0;
        i_seed      = 16'h0;
`endif
        exp_word = 16'hACE1;
        #1;
        check("reset gnt forced", {28'h0, o_gnt}, 32'h0);
        check("reset valid", {31'h0, o_valid}, 32'h0);
        repeat (2) @(posedge i_clk);
        #1;
        i_s_rst = 1'b0;
        check("reset data", {16'h0, o_data}, 32'h0000ACE1);

        // Idle: nothing granted, LFSR holds.
        for (int i = 0; i < 10; i++) do_cycle($sformatf("idle%0d", i), 4'b0000, 4'b0000);

        // Single requester 0: consecutive words.
        check("word0 literal", {16'h0, exp_word}, 32'h0000ACE1);
        do_cycle("solo0 a", 4'b0001, 4'b0001);
        check("word1 literal", {16'h0, o_data}, 32'h0000E270);
        do_cycle("solo0 b", 4'b0001, 4'b0001);
        check("word2 literal", {16'h0, o_data}, 32'h00007138);
        do_cycle("solo0 c", 4'b0001, 4'b0001);

        // All requesting: rotation starts after last=0.
        for (int i = 0; i < 8; i++) do_cycle($sformatf("all%0d", i), 4'b1111, rr_seq[i]);

        // Make last=3, then wrap-around between 0 and 3.
        do_cycle("only3", 4'b1000, 4'b1000);
        do_cycle("wrap a", 4'b1001, 4'b0001);
        do_cycle("wrap b", 4'b1001, 4'b1000);
        do_cycle("wrap c", 4'b1001, 4'b0001);

        // Mid-stream reset.
        do_cycle("pre rst", 4'b0110, 4'b0010);
        i_s_rst = 1'b1;
        i_req   = 4'b0110;
        #1;
        check("mid rst gnt", {28'h0, o_gnt}, 32'h0);
        check("mid rst valid", {31'h0, o_valid}, 32'h0);
        @(posedge i_clk);
        #1;
        i_s_rst  = 1'b0;
        exp_word = 16'hACE1;
        do_cycle("post rst", 4'b0110, 4'b0010);

`ifdef RANDOM_WORD_ARBITER_SEED_LOAD_EN
        // Zero seed falls back to LFSR_SEED; the grant is suppressed.
        i_seed_load = 1'b1;
        i_seed      = 16'h0000;
        i_req       = 4'b0010;
        #1;
        check("seed0 gnt", {28'h0, o_gnt}, 32'h0);
        @(posedge i_clk);
        #1;
        i_seed_load = 1'b0;
        exp_word    = 16'hACE1;
        do_cycle("after seed0", 4'b0000, 4'b0000);
        i_seed_load = 1'b1;
        i_seed      = 16'h1234;
        i_req       = 4'b0010;
        #1;
        check("seed1234 gnt", {28'h0, o_gnt}, 32'h0);
        @(posedge i_clk);
        #1;
        i_seed_load = 1'b0;
        exp_word    = 16'h1234;
        do_cycle("after seed1234", 4'b0010, 4'b0010);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
